audio_track_sequencer: RTL and testbench
========================================

// Module: audio_track_sequencer
// PURPOSE
//  Parametrised successor to the top-level sample-rate/track-address counter feeding Audio_Controller.
//  Steps a ROM address at a programmable sample rate over one of N_TRACKS banks.
//  Supports loop or one-shot play, start/stop control, volume shift and underrun counting.
//  Sits between the game FSM (win/loss/oxygen cues) and the audio ROM + Audio_Controller.
// PARAMETERS
//  N_TRACKS     4      number of ROM banks; TS_W = max(1,$clog2(N_TRACKS))
//  ADDR_W       16     per-track sample address width
//  TRACK_LEN    64000  samples per track, 2..2**ADDR_W
//  RATE_DIV     6250   CLOCK_50 cycles per sample, >=1
//  SAMPLE_W     8      ROM sample width
//  OUT_W        32     audio channel width, >= SAMPLE_W+7
//  ROM_LATENCY  1      ROM read latency in cycles, 1..2
// PORTS
//  CLOCK_50          in   1         system clock
//  resetn            in   1         asynchronous, active-low reset
//  start             in   1         1-cycle pulse: latch track_sel/loop_en, play from sample 0
//  stop              in   1         1-cycle pulse: abort to IDLE, no done
//  track_sel         in   TS_W      bank to play (sampled on start only)
//  loop_en           in   1         1=wrap at end, 0=one-shot (sampled on start only)
//  vol_shift         in   3         left shift applied to sample (live)
//  rom_bank          out  TS_W      ROM bank select
//  rom_addr          out  ADDR_W    ROM sample address
//  rom_q             in   SAMPLE_W  ROM data, valid ROM_LATENCY cycles after address
//  audio_out_allowed in   1         Audio_Controller FIFO has space
//  write_audio_out   out  1         write strobe to Audio_Controller
//  left_audio_out    out  OUT_W     left channel sample
//  right_audio_out   out  OUT_W     right channel sample (= left)
//  busy              out  1         high in PLAY
//  done              out  1         1-cycle pulse at one-shot end
//  underrun_cnt      out  8         saturating count of missed sample periods
// BEHAVIOUR
//  Reset: state IDLE, all outputs/registers 0 (underrun_cnt included).
//  FSM IDLE->PLAY on start. PLAY->IDLE on stop; PLAY->IDLE on end-of-track tick if !loop_q (done=1 same cycle).
//  stop has priority over start in the same cycle. start in PLAY restarts: addr=0, divider=0, new bank/mode.
//  Divider: counts 0..RATE_DIV-1 in PLAY; tick when count==RATE_DIV-1; cleared in IDLE and on start.
//  RATE_DIV=1: tick every PLAY cycle.
//  Address: 0 on start; +1 per tick. At tick with addr==TRACK_LEN-1: wrap to 0 (loop) or end (one-shot).
//  Each sample is presented for a full RATE_DIV period, including the last.
//  ROM pipeline: valid shift of depth ROM_LATENCY follows each addr change (incl. start).
//  sample_q <= rom_q when the pipeline output is valid. First sample lands ROM_LATENCY+1 cycles after start.
//  Output: left = right = ({OUT_W{0}} | sample_q) << vol_shift; zero-extended, no overflow by OUT_W rule.
//  Output forced to 0 in IDLE; sample_q cleared on entry to IDLE.
//  write_audio_out = audio_out_allowed & busy (combinational); one sample per allowed cycle.
//  Underrun: track "seen_allowed" per sample period, cleared each tick. At tick with seen==0, underrun_cnt += 1, saturating at 255.
//  underrun_cnt clears only on reset.
//  rom_bank holds the latched track_sel; held after end. rom_addr returns to 0 in IDLE.
// STRUCTURE
//  audio_pkg: state enum {S_IDLE,S_PLAY}, underrun width/saturation localparam, TS_W function.
//  Sub-module rate_tick_gen #(RATE_DIV): clear/enable in, tick out.
//  Remainder (FSM, address, ROM pipeline, scaling, underrun) is inline.
// TESTING (bench params: N_TRACKS=4, TRACK_LEN=4, RATE_DIV=3, ROM_LATENCY=1, ROM word = {bank,addr})
//  1 One-shot: track_sel=2, loop_en=0, start.
//    -> rom_addr 0,1,2,3 each held 3 cycles; done pulses once at cycle 12; busy falls; outputs 0.
//  2 Loop: loop_en=1, start, run 30 cycles.
//    -> rom_addr sequence 0..3,0..3 repeating; done never asserts.
//  3 Volume + scaling: sample 8'h05, vol_shift=3 -> left=right=32'h28; vol_shift=0 -> 32'h05.
//  4 Priority: start and stop in the same cycle during PLAY -> IDLE, no done.
//    Start in PLAY at addr 2 -> rom_addr 0, new bank.
//  5 Underrun: hold audio_out_allowed=0 for 4 ticks -> underrun_cnt=4.
//    Hold for 300 ticks -> 255. write_audio_out is 0 throughout.
//  6 Async reset: assert resetn=0 mid-PLAY between clock edges.
//    -> all outputs 0 immediately; after release, IDLE until the next start.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio track sequencer.
package audio_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PLAY = 1'b1
  } state_e;

  localparam int unsigned         UNDER_W   = 8;
  localparam logic [UNDER_W-1:0]  UNDER_MAX = '1;

  // Track-select width; a single-track build still needs a 1-bit bank port.
  function automatic int unsigned ts_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rate_tick_gen.sv
// Sample-period divider: counts 0..RATE_DIV-1 while enabled, tick_c on the last count.
module rate_tick_gen #(
  parameter int unsigned RATE_DIV = 6250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_c
);

  localparam int unsigned      CNT_W   = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATE_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_c = en_i & ~clear_i & (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)   cnt_d = '0;
    else if (en_i) cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/audio_track_sequencer.sv
// Steps a ROM address per sample period over a selected track bank, scales the
// returned sample and feeds it to the audio controller; counts missed periods.
module audio_track_sequencer
  import audio_pkg::*;
#(
  parameter int unsigned N_TRACKS    = 4,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned TRACK_LEN   = 64000,
  parameter int unsigned RATE_DIV    = 6250,
  parameter int unsigned SAMPLE_W    = 8,
  parameter int unsigned OUT_W       = 32,
  parameter int unsigned ROM_LATENCY = 1,
  localparam int unsigned TS_W       = ts_width(N_TRACKS)
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                start,
  input  logic                stop,
  input  logic [TS_W-1:0]     track_sel,
  input  logic                loop_en,
  input  logic [2:0]          vol_shift,
  output logic [TS_W-1:0]     rom_bank,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [SAMPLE_W-1:0] rom_q,
  input  logic                audio_out_allowed,
  output logic                write_audio_out,
  output logic [OUT_W-1:0]    left_audio_out,
  output logic [OUT_W-1:0]    right_audio_out,
  output logic                busy,
  output logic                done,
  output logic [7:0]          underrun_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TRACK_LEN - 1);

  state_e               state_q, state_d;
  logic [TS_W-1:0]      bank_q, bank_d;
  logic                 loop_q, loop_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [ROM_LATENCY:0] vld_q, vld_d;
  logic [SAMPLE_W-1:0]  sample_q, sample_d;
  logic [OUT_W-1:0]     out_q, out_d;
  logic                 seen_q, seen_d;
  logic [UNDER_W-1:0]   under_q, under_d;
  logic                 done_q, done_d;
  logic                 addr_chg;
  logic                 restart;
  logic                 tick;
  logic                 seen_now;

  rate_tick_gen #(.RATE_DIV(RATE_DIV)) u_tick (
    .clk     (CLOCK_50),
    .rst_n   (resetn),
    .clear_i ((state_q == S_IDLE) | start | stop),
    .en_i    (state_q == S_PLAY),
    .tick_c  (tick)
  );

  assign restart  = start & ~stop;
  assign seen_now = seen_q | audio_out_allowed;

  // Next state: stop beats start, start beats the sample tick.
  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    loop_d   = loop_q;
    addr_d   = addr_q;
    seen_d   = 1'b0;
    under_d  = under_q;
    done_d   = 1'b0;
    addr_chg = 1'b0;
    if (state_q == S_PLAY && stop) begin
      state_d = S_IDLE;
      addr_d  = '0;
    end else if (restart) begin
      state_d  = S_PLAY;
      bank_d   = track_sel;
      loop_d   = loop_en;
      addr_d   = '0;
      addr_chg = 1'b1;
    end else if (state_q == S_PLAY) begin
      seen_d = seen_now;
      if (tick) begin
        seen_d = 1'b0;
        if (!seen_now && under_q != UNDER_MAX) under_d = under_q + UNDER_W'(1);
        if (addr_q != LAST_ADDR) begin
          addr_d   = addr_q + ADDR_W'(1);
          addr_chg = 1'b1;
        end else if (loop_q) begin
          addr_d   = '0;
          addr_chg = 1'b1;
        end else begin
          state_d = S_IDLE;
          addr_d  = '0;
          done_d  = 1'b1;
        end
      end
    end
  end

  // The valid pipe is one stage deeper than the ROM since the address itself is registered.
  always_comb begin
    vld_d    = '0;
    sample_d = '0;
    out_d    = '0;
    if (state_d == S_PLAY) begin
      vld_d    = {vld_q[ROM_LATENCY-1:0], addr_chg};
      sample_d = vld_q[ROM_LATENCY] ? rom_q : sample_q;
      out_d    = OUT_W'(sample_d) << vol_shift;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      bank_q   <= '0;
      loop_q   <= 1'b0;
      addr_q   <= '0;
      vld_q    <= '0;
      sample_q <= '0;
      out_q    <= '0;
      seen_q   <= 1'b0;
      under_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bank_q   <= bank_d;
      loop_q   <= loop_d;
      addr_q   <= addr_d;
      vld_q    <= vld_d;
      sample_q <= sample_d;
      out_q    <= out_d;
      seen_q   <= seen_d;
      under_q  <= under_d;
      done_q   <= done_d;
    end
  end

  assign busy            = (state_q == S_PLAY);
  assign write_audio_out = audio_out_allowed & busy;
  assign rom_bank        = bank_q;
  assign rom_addr        = addr_q;
  assign left_audio_out  = out_q;
  assign right_audio_out = out_q;
  assign done            = done_q;
  assign underrun_cnt    = under_q;

endmodule

// File: tb/tb_audio_track_sequencer.sv
// Directed bench for audio_track_sequencer with a {bank,addr} ROM model.
module tb_audio_track_sequencer;

  localparam int unsigned TS_W = 2;
  localparam int unsigned AW   = 6;

  logic            clk = 1'b0;
  logic            resetn;
  logic            start, stop, loop_en, allowed;
  logic [TS_W-1:0] track_sel;
  logic [2:0]      vol_shift;
  logic [TS_W-1:0] rom_bank;
  logic [AW-1:0]   rom_addr;
  logic [7:0]      rom_q = '0;
  logic            rom_ovr;
  logic [7:0]      rom_ovr_val;
  logic            wr;
  logic [31:0]     left, right;
  logic            busy, done;
  logic [7:0]      underrun_cnt;

  int checks   = 0;
  int failures = 0;

  audio_track_sequencer #(
    .N_TRACKS(4), .ADDR_W(AW), .TRACK_LEN(4), .RATE_DIV(3),
    .SAMPLE_W(8), .OUT_W(32), .ROM_LATENCY(1)
  ) dut (
    .CLOCK_50(clk), .resetn(resetn), .start(start), .stop(stop),
    .track_sel(track_sel), .loop_en(loop_en), .vol_shift(vol_shift),
    .rom_bank(rom_bank), .rom_addr(rom_addr), .rom_q(rom_q),
    .audio_out_allowed(allowed), .write_audio_out(wr),
    .left_audio_out(left), .right_audio_out(right),
    .busy(busy), .done(done), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom_ovr ? rom_ovr_val : {rom_bank, rom_addr};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after the capturing posedge.
  task automatic pulse(input logic s, input logic p);
    start = s;
    stop  = p;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    logic wr_seen;
    resetn = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; allowed = 1'b1;
    track_sel = '0; vol_shift = '0; rom_ovr = 1'b0; rom_ovr_val = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_addr", 64'(rom_addr), 64'd0);
    check("rst_left", 64'(left), 64'd0);
    check("rst_under", 64'(underrun_cnt), 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);

    // One-shot on bank 2
    track_sel = 2'd2; loop_en = 1'b0;
    pulse(1'b1, 1'b0);
    for (int c = 0; c < 12; c++) begin
      check("t1_addr", 64'(rom_addr), 64'(c / 3));
      check("t1_done_low", 64'(done), 64'd0);
      check("t1_busy", 64'(busy), 64'd1);
      if (c == 5)  check("t1_left5", 64'(left), 64'h81);
      if (c == 11) begin
        check("t1_left11", 64'(left), 64'h83);
        check("t1_right11", 64'(right), 64'h83);
      end
      @(negedge clk);
    end
    check("t1_done", 64'(done), 64'd1);
    check("t1_busy_end", 64'(busy), 64'd0);
    check("t1_addr_end", 64'(rom_addr), 64'd0);
    check("t1_left_end", 64'(left), 64'd0);
    check("t1_bank_held", 64'(rom_bank), 64'd2);
    @(negedge clk);
    check("t1_done_pulse", 64'(done), 64'd0);

    // Loop on bank 1
    track_sel = 2'd1; loop_en = 1'b1;
    pulse(1'b1, 1'b0);
    for (int c = 0; c < 30; c++) begin
      check("t2_addr", 64'(rom_addr), 64'((c / 3) % 4));
      check("t2_done_low", 64'(done), 64'd0);
      @(negedge clk);
    end
    pulse(1'b0, 1'b1);
    check("t2_stop_busy", 64'(busy), 64'd0);
    check("t2_stop_done", 64'(done), 64'd0);
    check("t2_stop_addr", 64'(rom_addr), 64'd0);
    check("t2_bank_held", 64'(rom_bank), 64'd1);

    // Volume scaling with a forced ROM word
    rom_ovr = 1'b1; rom_ovr_val = 8'h05; vol_shift = 3'd3;
    track_sel = 2'd0;
    pulse(1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("t3_left_sh3", 64'(left), 64'h28);
    check("t3_right_sh3", 64'(right), 64'h28);
    check("t3_write", 64'(wr), 64'd1);
    vol_shift = 3'd0;
    @(negedge clk);
    check("t3_left_sh0", 64'(left), 64'h05);
    check("t3_right_sh0", 64'(right), 64'h05);

    // Simultaneous start+stop in PLAY, then restart from addr 2
    pulse(1'b1, 1'b1);
    check("t4_prio_busy", 64'(busy), 64'd0);
    check("t4_prio_done", 64'(done), 64'd0);
    check("t4_prio_left", 64'(left), 64'd0);
    rom_ovr = 1'b0;
    track_sel = 2'd3;
    pulse(1'b1, 1'b0);
    repeat (6) @(negedge clk);
    check("t4_addr2", 64'(rom_addr), 64'd2);
    check("t4_bank3", 64'(rom_bank), 64'd3);
    track_sel = 2'd1;
    pulse(1'b1, 1'b0);
    check("t4_re_addr", 64'(rom_addr), 64'd0);
    check("t4_re_bank", 64'(rom_bank), 64'd1);
    check("t4_re_busy", 64'(busy), 64'd1);
    check("t4_re_done", 64'(done), 64'd0);
    pulse(1'b0, 1'b1);
    check("t4_stop_busy", 64'(busy), 64'd0);

    // Underrun counting and saturation
    check("t5_under0", 64'(underrun_cnt), 64'd0);
    allowed = 1'b0; track_sel = 2'd2; loop_en = 1'b1;
    pulse(1'b1, 1'b0);
    wr_seen = 1'b0;
    for (int c = 0; c <= 900; c++) begin
      if (wr) wr_seen = 1'b1;
      if (c == 11)  check("t5_under3", 64'(underrun_cnt), 64'd3);
      if (c == 12)  check("t5_under4", 64'(underrun_cnt), 64'd4);
      if (c == 764) check("t5_under254", 64'(underrun_cnt), 64'd254);
      if (c == 765) check("t5_under255", 64'(underrun_cnt), 64'd255);
      if (c == 900) check("t5_under_sat", 64'(underrun_cnt), 64'd255);
      @(negedge clk);
    end
    check("t5_no_write", 64'(wr_seen), 64'd0);
    allowed = 1'b1;
    #1;
    check("t5_write_on", 64'(wr), 64'd1);

    // Asynchronous reset between edges
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_left", 64'(left), 64'd0);
    check("t6_right", 64'(right), 64'd0);
    check("t6_under", 64'(underrun_cnt), 64'd0);
    check("t6_addr", 64'(rom_addr), 64'd0);
    check("t6_bank", 64'(rom_bank), 64'd0);
    check("t6_write", 64'(wr), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    check("t6_idle_busy", 64'(busy), 64'd0);
    check("t6_idle_addr", 64'(rom_addr), 64'd0);
    track_sel = 2'd1; loop_en = 1'b0;
    pulse(1'b1, 1'b0);
    check("t6_start_busy", 64'(busy), 64'd1);
    check("t6_start_bank", 64'(rom_bank), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
